// File: rtl/cache_pkg.sv
// Shared cache-subsystem constants: word/fetch sizes and memory-port owner encodings.
package cache_pkg;
  localparam int WORD_SIZE  = 16;
  localparam int FETCH_SIZE = 64;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_I    = 2'b01,
    OWN_D    = 2'b10
  } owner_e;
endpackage

// File: rtl/arb2_rr.sv
// Two-input round-robin grant. On a tie the side that was not served last wins;
// the last-served side is recorded whenever update is pulsed.
module arb2_rr (
  input  logic clk,
  input  logic reset_n,
  input  logic req_a,
  input  logic req_b,
  input  logic update,
  input  logic served_b,
  output logic grant_a,
  output logic grant_b
);
  // After reset side a counts as last served, so the first tie goes to b.
  logic last_b;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    last_b <= 1'b0;
    else if (update) last_b <= served_b;
  end

  always_comb begin
    grant_a = req_a && (!req_b || last_b);
    grant_b = req_b && (!req_a || !last_b);
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency 64-bit memory port between I-cache fills and D-cache
// fills/write-backs; each cache holds a level request until its done pulse.
//
//   state     | meaning
//   ST_IDLE   | port free, arbitrate between pending requests
//   ST_ACCESS | strobe held for MEM_LATENCY cycles, read line captured in last one
//   ST_DONE   | pulse owner's done, record last owner, requests ignored
module mem_port_arbiter
  import cache_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int LINE_W      = FETCH_SIZE,
  parameter int MEM_LATENCY = 4,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_req_rd,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_req_rd,
  input  logic              d_req_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_done,
  output logic [LINE_W-1:0] d_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic [1:0]        owner,
  output logic [CNT_W-1:0]  conflict_cnt
);
  localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_e;

  state_e            state, state_nxt;
  logic [LAT_W-1:0]  lat_cnt;
  owner_e            own;
  logic              op_wr;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              d_any, grant_i, grant_d;

  assign d_any = d_req_rd | d_req_wr;

  arb2_rr u_arb (
    .clk      (clk),
    .reset_n  (reset_n),
    .req_a    (i_req_rd),
    .req_b    (d_any),
    .update   (state == ST_DONE),
    .served_b (own == OWN_D),
    .grant_a  (grant_i),
    .grant_b  (grant_d)
  );

  always_comb begin
    state_nxt = state;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    i_done    = 1'b0;
    d_done    = 1'b0;
    owner     = own;
    case (state)
      ST_IDLE:   if (grant_i || grant_d) state_nxt = ST_ACCESS;
      ST_ACCESS: begin
        mem_read  = !op_wr;
        mem_write = op_wr;
        mem_addr  = addr_q;
        mem_wdata = op_wr ? wdata_q : '0;
        if (lat_cnt == '0) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        i_done    = (own == OWN_I);
        d_done    = (own == OWN_D);
        state_nxt = ST_IDLE;
      end
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      lat_cnt      <= '0;
      own          <= OWN_NONE;
      op_wr        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      i_rdata      <= '0;
      d_rdata      <= '0;
      conflict_cnt <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (i_req_rd && d_any && conflict_cnt != '1) conflict_cnt <= conflict_cnt + 1'b1;
          // A simultaneous read+write from D resolves to the write-back.
          if (grant_d) begin
            own     <= OWN_D;
            op_wr   <= d_req_wr;
            addr_q  <= d_addr;
            wdata_q <= d_wdata;
            lat_cnt <= LAT_LOAD;
          end else if (grant_i) begin
            own     <= OWN_I;
            op_wr   <= 1'b0;
            addr_q  <= i_addr;
            wdata_q <= '0;
            lat_cnt <= LAT_LOAD;
          end
        end
        ST_ACCESS: begin
          // Write-backs return nothing, so d_rdata keeps the last fetched line.
          if (lat_cnt == '0) begin
            if (!op_wr && own == OWN_I) i_rdata <= mem_rdata;
            if (!op_wr && own == OWN_D) d_rdata <= mem_rdata;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        ST_DONE: own <= OWN_NONE;
        default: own <= OWN_NONE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && state == ST_IDLE)
      assert (!(d_req_rd && d_req_wr))
        else $warning("d_req_rd and d_req_wr raised together; write-back taken");
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Two arbiter builds (latency 4 / 16-bit counter, latency 1 / 3-bit counter) checked
// every cycle against a transaction-level timing model, plus directed scenarios.
module tb_mem_port_arbiter;
  localparam int AW = 16;
  localparam int LW = 64;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]         i_req_rd = '0, d_req_rd = '0, d_req_wr = '0;
  logic [1:0][AW-1:0] i_addr = '0, d_addr = '0;
  logic [1:0][LW-1:0] d_wdata = '0;
  logic [1:0]         i_done, d_done, mem_read, mem_write;
  logic [1:0][AW-1:0] mem_addr;
  logic [1:0][LW-1:0] i_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [1:0][1:0]    owner;
  logic [15:0]        cc0;
  logic [2:0]         cc1;

  int tests = 0;
  int failed = 0;

  function automatic logic [63:0] line_of(input logic [15:0] a);
    if (a == 16'h0120) return 64'hAAAA_BBBB_CCCC_DDDD;
    return {a ^ 16'h1234, ~a, a + 16'h0F0F, a[7:0], a[15:8]};
  endfunction

  assign mem_rdata[0] = line_of(mem_addr[0]);
  assign mem_rdata[1] = line_of(mem_addr[1]);

  mem_port_arbiter #(.ADDR_W(AW), .LINE_W(LW), .MEM_LATENCY(4), .CNT_W(16)) dut0 (
    .clk(clk), .reset_n(reset_n),
    .i_req_rd(i_req_rd[0]), .i_addr(i_addr[0]), .i_done(i_done[0]), .i_rdata(i_rdata[0]),
    .d_req_rd(d_req_rd[0]), .d_req_wr(d_req_wr[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
    .d_done(d_done[0]), .d_rdata(d_rdata[0]),
    .mem_read(mem_read[0]), .mem_write(mem_write[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]),
    .owner(owner[0]), .conflict_cnt(cc0));

  mem_port_arbiter #(.ADDR_W(AW), .LINE_W(LW), .MEM_LATENCY(1), .CNT_W(3)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .i_req_rd(i_req_rd[1]), .i_addr(i_addr[1]), .i_done(i_done[1]), .i_rdata(i_rdata[1]),
    .d_req_rd(d_req_rd[1]), .d_req_wr(d_req_wr[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
    .d_done(d_done[1]), .d_rdata(d_rdata[1]),
    .mem_read(mem_read[1]), .mem_write(mem_write[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]),
    .owner(owner[1]), .conflict_cnt(cc1));

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Reference model: one outstanding transaction per build, described by who owns it,
  // what it does and the cycle it was granted; outputs follow from cycle offsets.
  int          lat [2] = '{4, 1};
  longint      cmax[2] = '{65535, 7};
  bit          m_act [2];
  int          m_t0  [2];
  int          m_who [2];     // 1 = I, 2 = D
  bit          m_wr  [2];
  logic [15:0] m_addr[2];
  logic [63:0] m_wdat[2];
  int          m_last[2];
  logic [63:0] m_ird [2], m_drd[2];
  longint      m_conf[2];
  int          cyc = 0;

  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        int rel, own, win;
        bit strobe, done, free, ireq, dreq;
        string p;
        p = $sformatf("u%0d", k);
        if (!reset_n) begin
          m_act[k] = 0; m_last[k] = 1; m_ird[k] = '0; m_drd[k] = '0; m_conf[k] = 0;
        end
        rel    = cyc - m_t0[k];
        strobe = m_act[k] && rel >= 1 && rel <= lat[k];
        done   = m_act[k] && rel == lat[k] + 1;
        own    = (strobe || done) ? m_who[k] : 0;
        if (done && !m_wr[k]) begin
          if (m_who[k] == 1) m_ird[k] = line_of(m_addr[k]);
          else               m_drd[k] = line_of(m_addr[k]);
        end
        if (done) m_last[k] = m_who[k];

        chk({p, " mem_read"},  mem_read[k],  strobe && !m_wr[k]);
        chk({p, " mem_write"}, mem_write[k], strobe && m_wr[k]);
        chk({p, " mem_addr"},  mem_addr[k],  strobe ? m_addr[k] : 16'h0);
        chk({p, " mem_wdata"}, mem_wdata[k], (strobe && m_wr[k]) ? m_wdat[k] : 64'h0);
        chk({p, " owner"},     owner[k],     own);
        chk({p, " i_done"},    i_done[k],    done && m_who[k] == 1);
        chk({p, " d_done"},    d_done[k],    done && m_who[k] == 2);
        chk({p, " i_rdata"},   i_rdata[k],   m_ird[k]);
        chk({p, " d_rdata"},   d_rdata[k],   m_drd[k]);
        chk({p, " conflict"},  (k == 0) ? 64'(cc0) : 64'(cc1), m_conf[k]);

        if (reset_n) begin
          free = !m_act[k];
          if (done) m_act[k] = 0;
          ireq = i_req_rd[k];
          dreq = d_req_rd[k] || d_req_wr[k];
          if (free) begin
            if (ireq && dreq && m_conf[k] < cmax[k]) m_conf[k]++;
            win = (ireq && dreq) ? ((m_last[k] == 1) ? 2 : 1) : (dreq ? 2 : (ireq ? 1 : 0));
            if (win != 0) begin
              m_act[k] = 1; m_t0[k] = cyc; m_who[k] = win;
              m_wr[k]   = (win == 2) && d_req_wr[k];
              m_addr[k] = (win == 2) ? d_addr[k] : i_addr[k];
              m_wdat[k] = d_wdata[k];
            end
          end
        end
      end
      cyc++;
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_req_rd = '0; d_req_rd = '0; d_req_wr = '0;
    reset_n = 1'b0;
    nxt(); nxt();
    reset_n = 1'b1;
  endtask

  bit i_pend[2], d_pend[2], d_isw[2];
  bit s_idone[2], s_ddone[2], s_iown[2], s_down[2];

  task automatic rand_cycle();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      s_idone[k] = i_done[k]; s_ddone[k] = d_done[k];
      s_iown[k] = (owner[k] == 2'b01); s_down[k] = (owner[k] == 2'b10);
    end
    nxt();
    for (int k = 0; k < 2; k++) begin
      if (i_pend[k] && (s_idone[k] || (s_iown[k] && $urandom_range(0, 15) == 0))) i_pend[k] = 0;
      else if (!i_pend[k] && $urandom_range(0, 2) == 0) begin
        i_pend[k] = 1;
        i_addr[k] = ($urandom_range(0, 7) == 0) ? 16'h0120 : 16'($urandom);
      end
      if (d_pend[k] && (s_ddone[k] || (s_down[k] && $urandom_range(0, 15) == 0))) d_pend[k] = 0;
      else if (!d_pend[k] && $urandom_range(0, 2) == 0) begin
        d_pend[k]  = 1;
        d_isw[k]   = $urandom_range(0, 1) == 1;
        d_addr[k]  = 16'($urandom);
        d_wdata[k] = {$urandom, $urandom};
      end
      i_req_rd[k] = i_pend[k];
      d_req_rd[k] = d_pend[k] && !d_isw[k];
      d_req_wr[k] = d_pend[k] && d_isw[k];
    end
  endtask

  initial begin
    nxt(); nxt();
    reset_n = 1'b1;
    nxt();

    // Lone I read.
    i_req_rd[0] = 1; i_addr[0] = 16'h0120;
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      chk("t1 mem_read", mem_read[0], c >= 1 && c <= 4);
      chk("t1 i_done", i_done[0], c == 5);
      if (c == 1) chk("t1 owner", owner[0], 2'b01);
      if (c == 5) chk("t1 i_rdata", i_rdata[0], 64'hAAAA_BBBB_CCCC_DDDD);
      if (c == 6) chk("t1 conflict", cc0, 16'd0);
      nxt();
      if (c == 5) i_req_rd[0] = 0;
    end

    // Lone D write-back.
    d_req_wr[0] = 1; d_addr[0] = 16'h0340; d_wdata[0] = 64'h1111_2222_3333_4444;
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      chk("t2 mem_write", mem_write[0], c >= 1 && c <= 4);
      chk("t2 mem_read", mem_read[0], 1'b0);
      chk("t2 mem_wdata", mem_wdata[0], (c >= 1 && c <= 4) ? 64'h1111_2222_3333_4444 : 64'h0);
      chk("t2 d_done", d_done[0], c == 5);
      nxt();
      if (c == 5) d_req_wr[0] = 0;
    end

    // Simultaneous I and D reads straight after reset: D first.
    do_reset();
    i_req_rd[0] = 1; i_addr[0] = 16'h0200;
    d_req_rd[0] = 1; d_addr[0] = 16'h0300;
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      chk("t3 d_done", d_done[0], c == 5);
      chk("t3 i_done", i_done[0], c == 11);
      if (c == 1) chk("t3 owner first", owner[0], 2'b10);
      if (c == 7) chk("t3 owner second", owner[0], 2'b01);
      if (c == 12) chk("t3 conflict", cc0, 16'd1);
      nxt();
      if (c == 5) d_req_rd[0] = 0;
      if (c == 11) i_req_rd[0] = 0;
    end

    // Continuous contention alternates D,I,D,I (I was served last).
    i_req_rd[0] = 1; i_addr[0] = 16'h0410;
    d_req_rd[0] = 1; d_addr[0] = 16'h0420;
    for (int c = 0; c <= 24; c++) begin
      @(negedge clk);
      if (c == 1 || c == 13) chk("t4 owner D", owner[0], 2'b10);
      if (c == 7 || c == 19) chk("t4 owner I", owner[0], 2'b01);
      if (c == 24) chk("t4 conflict", cc0, 16'd5);
      nxt();
      if (c == 23) begin i_req_rd[0] = 0; d_req_rd[0] = 0; end
    end

    // Reset in the second ACCESS cycle of a D read.
    d_req_rd[0] = 1; d_addr[0] = 16'h0444;
    @(negedge clk); nxt();
    @(negedge clk);
    chk("t5 strobe before reset", mem_read[0], 1'b1);
    nxt();
    reset_n = 1'b0; d_req_rd[0] = 0;
    #1;
    chk("t5 strobe at reset", mem_read[0], 1'b0);
    chk("t5 owner at reset", owner[0], 2'b00);
    nxt(); nxt();
    reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("t5 no d_done", d_done[0], 1'b0);
      if (c == 0) chk("t5 conflict", cc0, 16'd0);
      nxt();
    end

    // Latency-1 build: lone I read, then D read+write together.
    i_req_rd[1] = 1; i_addr[1] = 16'h0777;
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      chk("t6 mem_read", mem_read[1], c == 1);
      chk("t6 i_done", i_done[1], c == 2);
      if (c == 2) chk("t6 i_rdata", i_rdata[1], 64'h1543_F888_1686_7707);
      nxt();
      if (c == 2) i_req_rd[1] = 0;
    end
    d_req_rd[1] = 1; d_req_wr[1] = 1; d_addr[1] = 16'h0888; d_wdata[1] = 64'h5555_6666_7777_8888;
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      chk("t6 rw mem_write", mem_write[1], c == 1);
      chk("t6 rw mem_read", mem_read[1], 1'b0);
      if (c == 1) chk("t6 rw mem_wdata", mem_wdata[1], 64'h5555_6666_7777_8888);
      chk("t6 rw d_done", d_done[1], c == 2);
      nxt();
      if (c == 2) begin d_req_rd[1] = 0; d_req_wr[1] = 0; end
    end

    // Saturating contention counter on the 3-bit build.
    i_req_rd[1] = 1; d_req_rd[1] = 1; d_addr[1] = 16'h0999;
    repeat (30) nxt();
    @(negedge clk);
    chk("t6 conflict saturated", cc1, 3'd7);
    nxt();
    i_req_rd[1] = 0; d_req_rd[1] = 0;
    repeat (4) nxt();

    // Randomized traffic on both builds.
    do_reset();
    repeat (4000) rand_cycle();
    i_req_rd = '0; d_req_rd = '0; d_req_wr = '0;
    repeat (8) nxt();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
